// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: state encodings, opcodes and keypad codes.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTER = 2'd1,
        EXEC  = 2'd2,
        SHOW  = 2'd3
    } calc_state_e;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [3:0] KEY_A = 4'd10;
    localparam logic [3:0] KEY_B = 4'd11;
    localparam logic [3:0] KEY_C = 4'd12;
    localparam logic [3:0] KEY_D = 4'd13;

    function automatic logic key_is_op(input logic [3:0] key);
        return (key >= KEY_A) && (key <= KEY_D);
    endfunction

    function automatic logic [1:0] key_to_op(input logic [3:0] key);
        logic [1:0] op;
        case (key)
            KEY_A:   op = OP_ADD;
            KEY_B:   op = OP_SUB;
            KEY_C:   op = OP_MUL;
            KEY_D:   op = OP_DIV;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/calc_sequencer_trig_conditioner.sv
// Push-button conditioning: 2-flop synchroniser, debounce counter and one-cycle rising-edge pulse.
module trig_conditioner
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DB_W            = 18
) (
    input  logic clock,
    input  logic ClearAll,
    input  logic trig_in,
    output logic pulse_out
);

    logic            sync1_r;
    logic            sync2_r;
    logic            level_r;
    logic            pulse_r;
    logic [DB_W-1:0] count_r;
    logic            differs_s;
    logic            expire_s;

    assign differs_s = sync2_r ^ level_r;
    assign expire_s  = differs_s && (count_r == DB_W'(DEBOUNCE_CYCLES - 1));
    assign pulse_out = pulse_r;

    // Metastability synchroniser for the raw button
    always_ff @(posedge clock or negedge ClearAll) begin
        if (!ClearAll) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= trig_in;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: the level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clock or negedge ClearAll) begin
        if (!ClearAll) begin
            count_r <= {DB_W{1'b0}};
            level_r <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            if (expire_s) begin
                count_r <= {DB_W{1'b0}};
                level_r <= sync2_r;
            end else if (differs_s) begin
                count_r <= count_r + DB_W'(1);
            end else begin
                count_r <= {DB_W{1'b0}};
            end
            pulse_r <= expire_s & sync2_r;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control sequencer: operand entry, execute and display, with a latched opcode.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int NUM_OPERANDS    = 2,
    parameter int IDX_W           = 3,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DB_W            = 18
) (
    input  logic                    clock,
    input  logic                    ClearAll,
    input  logic                    ClearEntry,
    input  logic                    trig,
    input  logic [3:0]              keyPressed,
    output logic [NUM_OPERANDS-1:0] load_operand,
    output logic [1:0]              op_sel,
    output logic                    load_result,
    output logic                    load_output,
    output logic                    iuau,
    output logic                    reset_iu,
    output logic [1:0]              state,
    output logic [IDX_W-1:0]        op_idx,
    output logic                    done
);

    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_OPERANDS - 1);
    localparam logic [NUM_OPERANDS-1:0] ONE_HOT0 = NUM_OPERANDS'(1);

    calc_state_e             state_r, next_state_s;
    logic [IDX_W-1:0]        op_idx_r, next_idx_s;
    logic [1:0]              op_sel_r, next_op_sel_s;
    logic [NUM_OPERANDS-1:0] load_operand_r, next_load_operand_s;
    logic                    load_result_r, next_load_result_s;
    logic                    load_output_r, next_load_output_s;
    logic                    iuau_r, next_iuau_s;
    logic                    reset_iu_r, next_reset_iu_s;
    logic                    done_r, next_done_s;
    logic                    clear_iu_s;
    logic                    trig_pulse_s;

    trig_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_W            (DB_W)
    ) u_trig (
        .clock     (clock),
        .ClearAll  (ClearAll),
        .trig_in   (trig),
        .pulse_out (trig_pulse_s)
    );

    // Next-state and operand index; ClearEntry takes priority over a trigger in ENTER
    always_comb begin
        next_state_s = state_r;
        next_idx_s   = op_idx_r;
        clear_iu_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (trig_pulse_s) begin
                    next_state_s = ENTER;
                    next_idx_s   = {IDX_W{1'b0}};
                end else begin
                    next_state_s = IDLE;
                end
            end
            ENTER: begin
                if (!ClearEntry) begin
                    clear_iu_s = 1'b1;
                end else if (trig_pulse_s) begin
                    if (op_idx_r >= LAST_IDX) begin
                        next_state_s = EXEC;
                    end else begin
                        next_idx_s = op_idx_r + IDX_W'(1);
                        clear_iu_s = 1'b1;
                    end
                end else begin
                    next_state_s = ENTER;
                end
            end
            EXEC: begin
                next_state_s = SHOW;
            end
            SHOW: begin
                if (trig_pulse_s) begin
                    next_state_s = IDLE;
                    next_idx_s   = {IDX_W{1'b0}};
                end else begin
                    next_state_s = SHOW;
                end
            end
            default: begin
                next_state_s = IDLE;
                next_idx_s   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Moore outputs decoded from the next state so they register alongside it
    always_comb begin
        next_load_operand_s = {NUM_OPERANDS{1'b0}};
        next_load_result_s  = 1'b0;
        next_load_output_s  = 1'b0;
        next_iuau_s         = 1'b0;
        next_reset_iu_s     = 1'b0;
        next_done_s         = 1'b0;
        case (next_state_s)
            IDLE: begin
                next_reset_iu_s = 1'b0;
            end
            ENTER: begin
                next_load_operand_s = ONE_HOT0 << next_idx_s;
                next_reset_iu_s     = ~clear_iu_s;
            end
            EXEC: begin
                next_load_result_s = 1'b1;
                next_reset_iu_s    = 1'b1;
            end
            SHOW: begin
                next_load_output_s = 1'b1;
                next_iuau_s        = 1'b1;
                next_reset_iu_s    = 1'b1;
                next_done_s        = (state_r != SHOW);
            end
            default: begin
                next_reset_iu_s = 1'b0;
            end
        endcase
    end

    // Opcode latch, open only while operands are being set up
    always_comb begin
        next_op_sel_s = op_sel_r;
        if (((state_r == IDLE) || (state_r == ENTER)) && key_is_op(keyPressed)) begin
            next_op_sel_s = key_to_op(keyPressed);
        end else begin
            next_op_sel_s = op_sel_r;
        end
    end

    // State and output registers
    always_ff @(posedge clock or negedge ClearAll) begin
        if (!ClearAll) begin
            state_r        <= IDLE;
            op_idx_r       <= {IDX_W{1'b0}};
            op_sel_r       <= OP_ADD;
            load_operand_r <= {NUM_OPERANDS{1'b0}};
            load_result_r  <= 1'b0;
            load_output_r  <= 1'b0;
            iuau_r         <= 1'b0;
            reset_iu_r     <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            op_idx_r       <= next_idx_s;
            op_sel_r       <= next_op_sel_s;
            load_operand_r <= next_load_operand_s;
            load_result_r  <= next_load_result_s;
            load_output_r  <= next_load_output_s;
            iuau_r         <= next_iuau_s;
            reset_iu_r     <= next_reset_iu_s;
            done_r         <= next_done_s;
        end
    end

    assign state        = state_r;
    assign op_idx       = op_idx_r;
    assign op_sel       = op_sel_r;
    assign load_operand = load_operand_r;
    assign load_result  = load_result_r;
    assign load_output  = load_output_r;
    assign iuau         = iuau_r;
    assign reset_iu     = reset_iu_r;
    assign done         = done_r;

endmodule
